pipeline_id_ex: RTL and testbench

PIPELINE_ID_EX -- requirements
Module: pipeline_id_ex

---
 rtl/pipeline_id_ex.sv | 239 +++++++++++++++++++++++
 tb/tb_pipeline_id_ex.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_id_ex.sv
// ID stage with register file, decoder, load-use hazard detection and the ID/EX pipeline register.
// Unsupported opcodes and invalid slots enter ID/EX as an all-zero bubble.
module pipeline_id_ex #(
    parameter  int XLEN    = 32,
    parameter  int REG_NUM = 32,
    localparam int AW      = $clog2(REG_NUM)
) (
    input  logic            clk_ID,
    input  logic            rst_ID,
    input  logic            valid_in_ID,
    input  logic [31:0]     Inst_in_ID,
    input  logic [XLEN-1:0] PC_in_ID,
    input  logic            RegWrite_in_ID,
    input  logic [AW-1:0]   Rd_addr_in_ID,
    input  logic [XLEN-1:0] Wt_data_ID,
    input  logic            flush_ID,
    input  logic            hold_ID,
    output logic            Stall_out_ID,
    output logic            valid_EX,
    output logic [XLEN-1:0] PC_EX,
    output logic [XLEN-1:0] Rs1_data_EX,
    output logic [XLEN-1:0] Rs2_data_EX,
    output logic [AW-1:0]   Rs1_addr_EX,
    output logic [AW-1:0]   Rs2_addr_EX,
    output logic [AW-1:0]   Rd_addr_EX,
    output logic [XLEN-1:0] Imm_EX,
    output logic            ALUSrc_B_EX,
    output logic [2:0]      ALU_control_EX,
    output logic            Branch_EX,
    output logic            BranchN_EX,
    output logic            MemRW_EX,
    output logic            Jump_EX,
    output logic [1:0]      MemtoReg_EX,
    output logic            RegWrite_EX
);

    typedef enum logic [6:0] {
        OP_R   = 7'b0110011,
        OP_I   = 7'b0010011,
        OP_LW  = 7'b0000011,
        OP_SW  = 7'b0100011,
        OP_BR  = 7'b1100011,
        OP_JAL = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_XOR = 3'b011,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [AW-1:0]   rs1_addr;
        logic [AW-1:0]   rs2_addr;
        logic [AW-1:0]   rd_addr;
        logic [XLEN-1:0] imm;
        logic            alu_src_b;
        alu_e            alu_ctl;
        logic            branch;
        logic            branch_n;
        logic            mem_rw;
        logic            jump;
        logic [1:0]      mem_to_reg;
        logic            reg_write;
    } idex_t;

    function automatic alu_e alu_from_funct(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_from_funct = sub ? ALU_SUB : ALU_ADD;
            3'b111:  alu_from_funct = ALU_AND;
            3'b110:  alu_from_funct = ALU_OR;
            3'b100:  alu_from_funct = ALU_XOR;
            3'b101:  alu_from_funct = ALU_SRL;
            3'b010:  alu_from_funct = ALU_SLT;
            default: alu_from_funct = ALU_ADD;
        endcase
    endfunction

    logic [XLEN-1:0] r_rf [REG_NUM];
    idex_t           r_ex;

    opcode_e         w_op;
    logic [2:0]      w_f3;
    logic [AW-1:0]   w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
    logic            w_legal, w_use_rs1, w_use_rs2, w_hazard;
    idex_t           w_dec;

    assign w_op  = opcode_e'(Inst_in_ID[6:0]);
    assign w_f3  = Inst_in_ID[14:12];
    assign w_rs1 = Inst_in_ID[15 +: AW];
    assign w_rs2 = Inst_in_ID[20 +: AW];
    assign w_rd  = Inst_in_ID[7 +: AW];

    assign w_imm_i = {{(XLEN-11){Inst_in_ID[31]}}, Inst_in_ID[30:20]};
    assign w_imm_s = {{(XLEN-11){Inst_in_ID[31]}}, Inst_in_ID[30:25], Inst_in_ID[11:7]};
    assign w_imm_b = {{(XLEN-12){Inst_in_ID[31]}}, Inst_in_ID[7], Inst_in_ID[30:25],
                      Inst_in_ID[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){Inst_in_ID[31]}}, Inst_in_ID[19:12], Inst_in_ID[20],
                      Inst_in_ID[30:21], 1'b0};

    // Write-through: a WB write to the address being read wins over the stored value.
    assign w_rs1_data = (w_rs1 == '0) ? '0 :
                        (RegWrite_in_ID && Rd_addr_in_ID == w_rs1) ? Wt_data_ID : r_rf[w_rs1];
    assign w_rs2_data = (w_rs2 == '0) ? '0 :
                        (RegWrite_in_ID && Rd_addr_in_ID == w_rs2) ? Wt_data_ID : r_rf[w_rs2];

    // NOTE: every signal driven here gets a default first, so no path leaves a latch.
    always_comb begin
        w_dec     = '0;
        w_legal   = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_op)
            OP_R: begin
                w_legal           = 1'b1;
                w_use_rs1         = 1'b1;
                w_use_rs2         = 1'b1;
                w_dec.alu_ctl     = alu_from_funct(w_f3, Inst_in_ID[30]);
                w_dec.reg_write   = 1'b1;
            end
            OP_I: begin
                w_legal           = 1'b1;
                w_use_rs1         = 1'b1;
                w_dec.alu_ctl     = alu_from_funct(w_f3, 1'b0);
                w_dec.alu_src_b   = 1'b1;
                w_dec.imm         = w_imm_i;
                w_dec.reg_write   = 1'b1;
            end
            OP_LW: begin
                w_legal           = 1'b1;
                w_use_rs1         = 1'b1;
                w_dec.alu_ctl     = ALU_ADD;
                w_dec.alu_src_b   = 1'b1;
                w_dec.imm         = w_imm_i;
                w_dec.mem_to_reg  = 2'b01;
                w_dec.reg_write   = 1'b1;
            end
            OP_SW: begin
                w_legal           = 1'b1;
                w_use_rs1         = 1'b1;
                w_use_rs2         = 1'b1;
                w_dec.alu_ctl     = ALU_ADD;
                w_dec.alu_src_b   = 1'b1;
                w_dec.imm         = w_imm_s;
                w_dec.mem_rw      = 1'b1;
            end
            OP_BR: begin
                if (w_f3[2:1] == 2'b00) begin
                    w_legal        = 1'b1;
                    w_use_rs1      = 1'b1;
                    w_use_rs2      = 1'b1;
                    w_dec.alu_ctl  = ALU_SUB;
                    w_dec.imm      = w_imm_b;
                    w_dec.branch   = ~w_f3[0];
                    w_dec.branch_n = w_f3[0];
                end
            end
            OP_JAL: begin
                w_legal           = 1'b1;
                w_dec.alu_ctl     = ALU_ADD;
                w_dec.imm         = w_imm_j;
                w_dec.jump        = 1'b1;
                w_dec.mem_to_reg  = 2'b10;
                w_dec.reg_write   = 1'b1;
            end
            default: ;
        endcase

        w_dec.valid    = 1'b1;
        w_dec.pc       = PC_in_ID;
        w_dec.rs1_data = w_rs1_data;
        w_dec.rs2_data = w_rs2_data;
        w_dec.rs1_addr = w_rs1;
        w_dec.rs2_addr = w_rs2;
        w_dec.rd_addr  = w_dec.reg_write ? w_rd : '0;
        if (!w_legal || !valid_in_ID)
            w_dec = '0;
    end

    // A load in EX whose destination this instruction reads cannot be forwarded in time.
    assign w_hazard = r_ex.valid && r_ex.reg_write && (r_ex.mem_to_reg == 2'b01) &&
                      (r_ex.rd_addr != '0) && valid_in_ID &&
                      ((w_use_rs1 && r_ex.rd_addr == w_rs1) ||
                       (w_use_rs2 && r_ex.rd_addr == w_rs2));

    assign Stall_out_ID = w_hazard | hold_ID;

    // NOTE: the register array is cleared by reset so no stale data survives it.
    always_ff @(posedge clk_ID) begin
        if (rst_ID) begin
            for (int i = 0; i < REG_NUM; i++)
                r_rf[i] <= '0;
        end else if (RegWrite_in_ID && Rd_addr_in_ID != '0) begin
            r_rf[Rd_addr_in_ID] <= Wt_data_ID;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_ID) begin
        if (rst_ID)
            r_ex <= '0;
        else if (flush_ID)
            r_ex <= '0;
        else if (hold_ID)
            r_ex <= r_ex;
        else if (w_hazard)
            r_ex <= '0;
        else
            r_ex <= w_dec;
    end

    assign valid_EX       = r_ex.valid;
    assign PC_EX          = r_ex.pc;
    assign Rs1_data_EX    = r_ex.rs1_data;
    assign Rs2_data_EX    = r_ex.rs2_data;
    assign Rs1_addr_EX    = r_ex.rs1_addr;
    assign Rs2_addr_EX    = r_ex.rs2_addr;
    assign Rd_addr_EX     = r_ex.rd_addr;
    assign Imm_EX         = r_ex.imm;
    assign ALUSrc_B_EX    = r_ex.alu_src_b;
    assign ALU_control_EX = r_ex.alu_ctl;
    assign Branch_EX      = r_ex.branch;
    assign BranchN_EX     = r_ex.branch_n;
    assign MemRW_EX       = r_ex.mem_rw;
    assign Jump_EX        = r_ex.jump;
    assign MemtoReg_EX    = r_ex.mem_to_reg;
    assign RegWrite_EX    = r_ex.reg_write;

endmodule

// File: tb/tb_pipeline_id_ex.sv
// Scoreboarded bench for pipeline_id_ex: a default instance (XLEN=32) and a 64-bit/16-register instance.
module tb_pipeline_id_ex;

    typedef struct {
        bit          ctl_only;
        bit          no_valid;
        logic        valid;
        logic [63:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1a, rs2a, rd;
        logic        alusrc;
        logic [2:0]  alu;
        logic        br, brn, memrw, jump;
        logic [1:0]  m2r;
        logic        regw;
    } exp_t;

    localparam logic [31:0] I_ADD6_5_0 = 32'h00028333;
    localparam logic [31:0] I_SUB10    = 32'h40628533;
    localparam logic [31:0] I_LW7      = 32'h0000A383;
    localparam logic [31:0] I_ADD8_7_2 = 32'h00238433;
    localparam logic [31:0] I_LW0      = 32'h0000A003;
    localparam logic [31:0] I_ADD8_0_2 = 32'h00200433;
    localparam logic [31:0] I_LW2      = 32'h0000A103;
    localparam logic [31:0] I_BNE      = 32'hFE209CE3;
    localparam logic [31:0] I_SW       = 32'h0020A223;
    localparam logic [31:0] I_ADDI     = 32'hFFF00493;
    localparam logic [31:0] I_ILL      = 32'h0000007F;
    localparam logic [31:0] I_JAL      = 32'hFFDFF0EF;
    localparam logic [31:0] I_ADD4_3_0 = 32'h00018233;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];

    // Instance A: default parameters
    logic        rst_a = 1'b1, valid_a = 1'b0, rw_a = 1'b0, flush_a = 1'b0, hold_a = 1'b0;
    logic [31:0] inst_a = '0, pc_a = '0, wd_a = '0;
    logic [4:0]  rd_a = '0;
    logic        stall_a, v_a, alusrc_a, br_a, brn_a, memrw_a, jump_a, regw_a;
    logic [31:0] pc_ex_a, rs1d_a, rs2d_a, imm_a;
    logic [4:0]  rs1a_a, rs2a_a, rdex_a;
    logic [2:0]  alu_a;
    logic [1:0]  m2r_a;

    pipeline_id_ex dut_a (
        .clk_ID(clk), .rst_ID(rst_a), .valid_in_ID(valid_a), .Inst_in_ID(inst_a),
        .PC_in_ID(pc_a), .RegWrite_in_ID(rw_a), .Rd_addr_in_ID(rd_a), .Wt_data_ID(wd_a),
        .flush_ID(flush_a), .hold_ID(hold_a), .Stall_out_ID(stall_a),
        .valid_EX(v_a), .PC_EX(pc_ex_a), .Rs1_data_EX(rs1d_a), .Rs2_data_EX(rs2d_a),
        .Rs1_addr_EX(rs1a_a), .Rs2_addr_EX(rs2a_a), .Rd_addr_EX(rdex_a), .Imm_EX(imm_a),
        .ALUSrc_B_EX(alusrc_a), .ALU_control_EX(alu_a), .Branch_EX(br_a), .BranchN_EX(brn_a),
        .MemRW_EX(memrw_a), .Jump_EX(jump_a), .MemtoReg_EX(m2r_a), .RegWrite_EX(regw_a)
    );

    // Instance B: wide datapath, small register file
    logic        rst_b = 1'b1, valid_b = 1'b0, rw_b = 1'b0, flush_b = 1'b0, hold_b = 1'b0;
    logic [31:0] inst_b = '0;
    logic [63:0] pc_b = '0, wd_b = '0;
    logic [3:0]  rd_b = '0;
    logic        stall_b, v_b, alusrc_b, br_b, brn_b, memrw_b, jump_b, regw_b;
    logic [63:0] pc_ex_b, rs1d_b, rs2d_b, imm_b;
    logic [3:0]  rs1a_b, rs2a_b, rdex_b;
    logic [2:0]  alu_b;
    logic [1:0]  m2r_b;

    pipeline_id_ex #(.XLEN(64), .REG_NUM(16)) dut_b (
        .clk_ID(clk), .rst_ID(rst_b), .valid_in_ID(valid_b), .Inst_in_ID(inst_b),
        .PC_in_ID(pc_b), .RegWrite_in_ID(rw_b), .Rd_addr_in_ID(rd_b), .Wt_data_ID(wd_b),
        .flush_ID(flush_b), .hold_ID(hold_b), .Stall_out_ID(stall_b),
        .valid_EX(v_b), .PC_EX(pc_ex_b), .Rs1_data_EX(rs1d_b), .Rs2_data_EX(rs2d_b),
        .Rs1_addr_EX(rs1a_b), .Rs2_addr_EX(rs2a_b), .Rd_addr_EX(rdex_b), .Imm_EX(imm_b),
        .ALUSrc_B_EX(alusrc_b), .ALU_control_EX(alu_b), .Branch_EX(br_b), .BranchN_EX(brn_b),
        .MemRW_EX(memrw_b), .Jump_EX(jump_b), .MemtoReg_EX(m2r_b), .RegWrite_EX(regw_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [63:0] pc, input logic [63:0] rs1d,
                                input logic [63:0] rs2d, input logic [4:0] rs1a,
                                input logic [4:0] rs2a, input logic [4:0] rd,
                                input logic [63:0] imm, input logic alusrc, input logic [2:0] alu,
                                input logic br, input logic brn, input logic memrw,
                                input logic jump, input logic [1:0] m2r, input logic regw);
        exp_t e;
        e.ctl_only = 1'b0; e.no_valid = 1'b0;
        e.valid = v; e.pc = pc; e.rs1d = rs1d; e.rs2d = rs2d; e.imm = imm;
        e.rs1a = rs1a; e.rs2a = rs2a; e.rd = rd; e.alusrc = alusrc; e.alu = alu;
        e.br = br; e.brn = brn; e.memrw = memrw; e.jump = jump; e.m2r = m2r; e.regw = regw;
        return e;
    endfunction

    function automatic exp_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00, 0);
    endfunction

    function automatic exp_t obs_a();
        exp_t o;
        o = mk(v_a, {32'b0, pc_ex_a}, {32'b0, rs1d_a}, {32'b0, rs2d_a}, rs1a_a, rs2a_a, rdex_a,
               {32'b0, imm_a}, alusrc_a, alu_a, br_a, brn_a, memrw_a, jump_a, m2r_a, regw_a);
        return o;
    endfunction

    function automatic exp_t obs_b();
        exp_t o;
        o = mk(v_b, pc_ex_b, rs1d_b, rs2d_b, {1'b0, rs1a_b}, {1'b0, rs2a_b}, {1'b0, rdex_b},
               imm_b, alusrc_b, alu_b, br_b, brn_b, memrw_b, jump_b, m2r_b, regw_b);
        return o;
    endfunction

    task automatic compare(input string tag, input exp_t o);
        exp_t e;
        e = sb_q.pop_front();
        if (!e.no_valid) check({tag, ".valid"}, 64'(o.valid), 64'(e.valid));
        check({tag, ".alusrc"}, 64'(o.alusrc), 64'(e.alusrc));
        check({tag, ".alu"},    64'(o.alu),    64'(e.alu));
        check({tag, ".br"},     64'(o.br),     64'(e.br));
        check({tag, ".brn"},    64'(o.brn),    64'(e.brn));
        check({tag, ".memrw"},  64'(o.memrw),  64'(e.memrw));
        check({tag, ".jump"},   64'(o.jump),   64'(e.jump));
        check({tag, ".m2r"},    64'(o.m2r),    64'(e.m2r));
        check({tag, ".regw"},   64'(o.regw),   64'(e.regw));
        if (!e.ctl_only) begin
            check({tag, ".pc"},   o.pc,   e.pc);
            check({tag, ".rs1d"}, o.rs1d, e.rs1d);
            check({tag, ".rs2d"}, o.rs2d, e.rs2d);
            check({tag, ".rs1a"}, 64'(o.rs1a), 64'(e.rs1a));
            check({tag, ".rs2a"}, 64'(o.rs2a), 64'(e.rs2a));
            check({tag, ".rd"},   64'(o.rd),   64'(e.rd));
            check({tag, ".imm"},  o.imm,  e.imm);
        end
    endtask

    task automatic step_a(input string tag, input logic rst, input logic valid,
                          input logic [31:0] inst, input logic [31:0] pc, input logic rw,
                          input logic [4:0] rd, input logic [31:0] wd, input logic flush,
                          input logic hold, input logic exp_stall, input exp_t e);
        @(negedge clk);
        rst_a = rst; valid_a = valid; inst_a = inst; pc_a = pc;
        rw_a = rw; rd_a = rd; wd_a = wd; flush_a = flush; hold_a = hold;
        #1;
        check({tag, ".stall"}, 64'(stall_a), 64'(exp_stall));
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag, obs_a());
    endtask

    task automatic step_b(input string tag, input logic rst, input logic valid,
                          input logic [31:0] inst, input logic [63:0] pc, input logic rw,
                          input logic [3:0] rd, input logic [63:0] wd,
                          input logic exp_stall, input exp_t e);
        @(negedge clk);
        rst_b = rst; valid_b = valid; inst_b = inst; pc_b = pc;
        rw_b = rw; rd_b = rd; wd_b = wd; flush_b = 1'b0; hold_b = 1'b0;
        #1;
        check({tag, ".stall"}, 64'(stall_b), 64'(exp_stall));
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare(tag, obs_b());
    endtask

    initial begin
        exp_t e_lw, e_sw, e_ill, e_inv;
        repeat (2) @(posedge clk);

        step_a("rst_hold", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, bubble());
        step_a("wb_x1", 0, 0, 0, 0, 1, 1, 32'h1000, 0, 0, 0, bubble());
        step_a("wb_x2", 0, 0, 0, 0, 1, 2, 32'h22, 0, 0, 0, bubble());
        step_a("add_byp", 0, 1, I_ADD6_5_0, 32'h100, 1, 5, 32'h1234, 0, 0, 0,
               mk(1, 'h100, 'h1234, 0, 5, 0, 6, 0, 0, 3'b010, 0, 0, 0, 0, 2'b00, 1));
        step_a("sub_byp", 0, 1, I_SUB10, 32'h104, 1, 6, 32'hABCD, 0, 0, 0,
               mk(1, 'h104, 'h1234, 'hABCD, 5, 6, 10, 0, 0, 3'b110, 0, 0, 0, 0, 2'b00, 1));
        e_lw = mk(1, 'h108, 'h1000, 0, 1, 0, 7, 0, 1, 3'b010, 0, 0, 0, 0, 2'b01, 1);
        step_a("lw_x7", 0, 1, I_LW7, 32'h108, 0, 0, 0, 0, 0, 0, e_lw);
        step_a("lu_haz", 0, 1, I_ADD8_7_2, 32'h10C, 0, 0, 0, 0, 0, 1, bubble());
        step_a("lu_issue", 0, 1, I_ADD8_7_2, 32'h10C, 1, 7, 32'h77, 0, 0, 0,
               mk(1, 'h10C, 'h77, 'h22, 7, 2, 8, 0, 0, 3'b010, 0, 0, 0, 0, 2'b00, 1));
        step_a("lw_x0", 0, 1, I_LW0, 32'h110, 0, 0, 0, 0, 0, 0,
               mk(1, 'h110, 'h1000, 0, 1, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 2'b01, 1));
        step_a("x0_nostall", 0, 1, I_ADD8_0_2, 32'h114, 0, 0, 0, 0, 0, 0,
               mk(1, 'h114, 0, 'h22, 0, 2, 8, 0, 0, 3'b010, 0, 0, 0, 0, 2'b00, 1));
        step_a("lw_x2", 0, 1, I_LW2, 32'h118, 0, 0, 0, 0, 0, 0,
               mk(1, 'h118, 'h1000, 0, 1, 0, 2, 0, 1, 3'b010, 0, 0, 0, 0, 2'b01, 1));
        step_a("flush_haz", 0, 1, I_BNE, 32'h11C, 0, 0, 0, 1, 0, 1, bubble());
        step_a("bne", 0, 1, I_BNE, 32'h11C, 0, 0, 0, 0, 0, 0,
               mk(1, 'h11C, 'h1000, 'h22, 1, 2, 0, 64'hFFFF_FFF8, 0, 3'b110, 0, 1, 0, 0, 2'b00, 0));
        e_sw = mk(1, 'h120, 'h1000, 'h22, 1, 2, 0, 4, 1, 3'b010, 0, 0, 1, 0, 2'b00, 0);
        step_a("sw", 0, 1, I_SW, 32'h120, 0, 0, 0, 0, 0, 0, e_sw);
        for (int i = 0; i < 3; i++)
            step_a($sformatf("hold%0d", i), 0, 1, I_ADDI, 32'h124, 0, 0, 0, 0, 1, 1, e_sw);
        step_a("addi", 0, 1, I_ADDI, 32'h124, 0, 0, 0, 0, 0, 0,
               mk(1, 'h124, 0, 0, 0, 31, 9, 64'hFFFF_FFFF, 1, 3'b010, 0, 0, 0, 0, 2'b00, 1));
        e_lw.pc = 'h128;
        step_a("lw_x7b", 0, 1, I_LW7, 32'h128, 0, 0, 0, 0, 0, 0, e_lw);
        step_a("rst_haz", 1, 1, I_ADD8_7_2, 32'h12C, 0, 0, 0, 0, 0, 1, bubble());
        step_a("rst_mask", 1, 1, I_ADD8_7_2, 32'h12C, 0, 0, 0, 0, 0, 0, bubble());
        step_a("x0_write", 0, 1, I_ADD8_0_2, 32'h200, 1, 0, 32'hFFFF, 0, 0, 0,
               mk(1, 'h200, 0, 0, 0, 2, 8, 0, 0, 3'b010, 0, 0, 0, 0, 2'b00, 1));
        step_a("x0_read", 0, 1, I_ADD8_0_2, 32'h204, 0, 0, 0, 0, 0, 0,
               mk(1, 'h204, 0, 0, 0, 2, 8, 0, 0, 3'b010, 0, 0, 0, 0, 2'b00, 1));
        step_a("rf_cleared", 0, 1, I_LW7, 32'h208, 0, 0, 0, 0, 0, 0,
               mk(1, 'h208, 0, 0, 1, 0, 7, 0, 1, 3'b010, 0, 0, 0, 0, 2'b01, 1));
        step_a("flush_hold", 0, 1, I_ADD8_7_2, 32'h20C, 0, 0, 0, 1, 1, 1, bubble());
        e_ill = bubble();
        e_ill.ctl_only = 1'b1;
        e_ill.no_valid = 1'b1;
        step_a("illegal", 0, 1, I_ILL, 32'h210, 0, 0, 0, 0, 0, 0, e_ill);
        e_inv = bubble();
        e_inv.ctl_only = 1'b1;
        step_a("invalid_in", 0, 0, I_ADD6_5_0, 32'h214, 0, 0, 0, 0, 0, 0, e_inv);

        step_b("b_rst", 1, 0, 0, 0, 0, 0, 0, 0, bubble());
        step_b("b_jal", 0, 1, I_JAL, 64'h300, 0, 0, 0, 0,
               mk(1, 'h300, 0, 0, 15, 13, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 3'b010, 0, 0, 0, 1, 2'b10, 1));
        step_b("b_byp64", 0, 1, I_ADD4_3_0, 64'h304, 1, 3, 64'hDEAD_BEEF_0000_0001, 0,
               mk(1, 'h304, 64'hDEAD_BEEF_0000_0001, 0, 3, 0, 4, 0, 0, 3'b010, 0, 0, 0, 0, 2'b00, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
